// File: rtl/trace_uart_tx_pkg.sv
// Shared orbtrace UART definitions: transmitter state encoding and frame constants.
package trace_uart_tx_pkg;

  // Serial transmitter frame phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Data bits carried per frame (8N1 / 8N2).
  localparam int unsigned UART_DATABITS = 8;

  // Level driven on the line between frames and during stop bits.
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Clock cycles occupied by one complete frame.
  function automatic int unsigned frame_cycles(input int unsigned bauddiv,
                                               input int unsigned stopbits);
    return (1 + UART_DATABITS + stopbits) * bauddiv;
  endfunction

endpackage

// File: rtl/trace_uart_tx_baud_tick.sv
// Bit-period timer: a down-counter that pulses tick on the last cycle of each
// bit period. restart realigns the period to the current edge so a new frame's
// start bit always gets a full period.
module trace_baud_tick #(
  parameter int unsigned BAUDDIV = 4
) (
  input  logic clk,
  input  logic rst,       // synchronous, active low
  input  logic restart,
  output logic tick,      // last cycle of the current bit period
  output logic pre_tick   // cycle before tick; lets the FSM pre-request a byte
);

  localparam logic [15:0] RELOAD = 16'(BAUDDIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tick     = (cnt_q == 16'd0);
  assign pre_tick = (cnt_q == 16'd1);

  // Reload on restart or period end, otherwise count down.
  always_comb begin
    cnt_d = cnt_q;
    if (restart || tick) begin
      cnt_d = RELOAD;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/trace_uart_tx.sv
// Serial back-end for the orbtrace byte stream. Pulls bytes over the
// DataNext/DataReady handshake and sends them LSB first as 8N1/8N2 frames,
// counts transmitted bytes and latches upstream overflow.
module trace_uart_tx
  import trace_uart_tx_pkg::*;
#(
  parameter int unsigned BAUDDIV  = 4,
  parameter int unsigned STOPBITS = 1,
  parameter int unsigned CNTW     = 16
) (
  input  logic            clk,
  input  logic            rst,          // synchronous, active low
  input  logic [7:0]      DataVal,
  input  logic            DataReady,
  input  logic            DataOverf,
  output logic            DataNext,
  output logic            txd,
  output logic            txBusy,
  output logic            overfSticky,
  input  logic            overfClr,
  output logic [CNTW-1:0] txCount
);

  // Elaboration-time parameter guards.
  if (BAUDDIV < 2 || BAUDDIV > 65535) begin : g_bad_bauddiv
    $error("trace_uart_tx: BAUDDIV must be in 2..65535");
  end
  if (STOPBITS != 1 && STOPBITS != 2) begin : g_bad_stopbits
    $error("trace_uart_tx: STOPBITS must be 1 or 2");
  end
  if (CNTW < 1) begin : g_bad_cntw
    $error("trace_uart_tx: CNTW must be at least 1");
  end

  localparam logic [2:0] LAST_BIT  = 3'(UART_DATABITS - 1);
  // Index of the final stop period (0 for one stop bit, 1 for two).
  localparam logic       STOP_LAST = (STOPBITS == 2);

  tx_state_e       state_q,    state_d;
  logic [7:0]      shift_q,    shift_d;
  logic [2:0]      bit_idx_q,  bit_idx_d;
  logic            stop_idx_q, stop_idx_d;
  logic            txd_q,      txd_d;
  logic            busy_q,     busy_d;
  logic            dnext_q,    dnext_d;
  logic [CNTW-1:0] count_q,    count_d;
  logic            overf_q,    overf_d;

  logic            launch;
  logic            tick;
  logic            pre_tick;
  logic            last_stop;

  assign last_stop = (stop_idx_q == STOP_LAST);

  // A launch restarts bit timing so the start bit is a full period long.
  trace_baud_tick #(
    .BAUDDIV (BAUDDIV)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart  (launch),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  // Frame sequencing, handshake and line level for the next cycle.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    dnext_d    = 1'b0;          // request is a single-cycle pulse
    count_d    = count_q;
    launch     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dnext_q) begin
          // Request was outstanding this cycle: consume if still offered.
          launch = DataReady;
        end else if (DataReady) begin
          dnext_d = 1'b1;
        end
      end

      START: begin
        if (tick) begin
          state_d   = DATA;
          txd_d     = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = 3'd0;
        end
      end

      DATA: begin
        if (tick) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d    = STOP;
            txd_d      = UART_IDLE_LEVEL;
            stop_idx_d = 1'b0;
            count_d    = count_q + CNTW'(1);
          end else begin
            txd_d     = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      STOP: begin
        // Pre-request so the ack lands on the final stop cycle: no idle gap.
        if (last_stop && pre_tick && DataReady) begin
          dnext_d = 1'b1;
        end
        if (tick) begin
          if (!last_stop) begin
            stop_idx_d = 1'b1;
          end else if (dnext_q && DataReady) begin
            launch = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        txd_d   = UART_IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase

    // Byte capture and start-bit launch, shared by IDLE and back-to-back paths.
    if (launch) begin
      state_d = START;
      shift_d = DataVal;
      txd_d   = 1'b0;
      busy_d  = 1'b1;
    end
  end

  // Overflow latch; a new overflow beats a simultaneous clear.
  always_comb begin
    overf_d = overf_q;
    if (DataOverf) begin
      overf_d = 1'b1;
    end else if (overfClr) begin
      overf_d = 1'b0;
    end
  end

  // State registers; reset abandons any frame in flight and idles the line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= 8'h00;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      txd_q      <= UART_IDLE_LEVEL;
      busy_q     <= 1'b0;
      dnext_q    <= 1'b0;
      count_q    <= '0;
      overf_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      dnext_q    <= dnext_d;
      count_q    <= count_d;
      overf_q    <= overf_d;
    end
  end

  assign DataNext    = dnext_q;
  assign txd         = txd_q;
  assign txBusy      = busy_q;
  assign overfSticky = overf_q;
  assign txCount     = count_q;

endmodule

// File: tb/tb_trace_uart_tx.sv
// Directed bench for trace_uart_tx: one instance at BAUDDIV=4/STOPBITS=1/CNTW=4
// and one at BAUDDIV=2/STOPBITS=2/CNTW=16, each fed by a queue-based builder.
module tb_trace_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [7:0]  dval_a, dval_b;
  logic        drdy_a, drdy_b;
  logic        dovf_a, dovf_b;
  logic        dclr_a, dclr_b;
  logic        dnext_a, dnext_b;
  logic        txd_a, txd_b;
  logic        busy_a, busy_b;
  logic        ovfs_a, ovfs_b;
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;

  trace_uart_tx #(.BAUDDIV(4), .STOPBITS(1), .CNTW(4)) u_dut_a (
    .clk(clk), .rst(rst), .DataVal(dval_a), .DataReady(drdy_a),
    .DataOverf(dovf_a), .DataNext(dnext_a), .txd(txd_a), .txBusy(busy_a),
    .overfSticky(ovfs_a), .overfClr(dclr_a), .txCount(cnt_a)
  );

  trace_uart_tx #(.BAUDDIV(2), .STOPBITS(2), .CNTW(16)) u_dut_b (
    .clk(clk), .rst(rst), .DataVal(dval_b), .DataReady(drdy_b),
    .DataOverf(dovf_b), .DataNext(dnext_b), .txd(txd_b), .txBusy(busy_b),
    .overfSticky(ovfs_b), .overfClr(dclr_b), .txCount(cnt_b)
  );

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int npulse_a = 0;
  int last_pulse_a = 0;
  int prev_pulse_a = 0;
  int consec_a = 0;
  int consec_b = 0;
  logic prev_dn_a = 1'b0;
  logic prev_dn_b = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh_inputs();
    drdy_a = (q_a.size() != 0);
    dval_a = drdy_a ? q_a[0] : 8'h00;
    drdy_b = (q_b.size() != 0);
    dval_b = drdy_b ? q_b[0] : 8'h00;
  endtask

  // Advance one clock; the builder pops a byte on every DataNext&DataReady edge.
  task automatic step();
    logic cons_a, cons_b;
    cons_a = dnext_a && drdy_a;
    cons_b = dnext_b && drdy_b;
    @(posedge clk);
    #1;
    cyc++;
    if (cons_a) q_a.delete(0);
    if (cons_b) q_b.delete(0);
    refresh_inputs();
    if (dnext_a) begin
      npulse_a++;
      prev_pulse_a = last_pulse_a;
      last_pulse_a = cyc;
      if (prev_dn_a) consec_a++;
    end
    if (dnext_b && prev_dn_b) consec_b++;
    prev_dn_a = dnext_a;
    prev_dn_b = dnext_b;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Check a whole frame cycle by cycle, starting on its first start-bit cycle.
  task automatic check_frame(input bit sel, input logic [7:0] b, input bit more);
    int bd, len, bi;
    logic exp_txd, o_txd, o_busy, o_dn;
    string nm;
    bd  = sel ? 2 : 4;
    len = sel ? 22 : 40;
    nm  = sel ? "b" : "a";
    for (int k = 0; k < len; k++) begin
      bi = k / bd;
      if (bi == 0)      exp_txd = 1'b0;
      else if (bi <= 8) exp_txd = b[3'(bi - 1)];
      else              exp_txd = 1'b1;
      o_txd  = sel ? txd_b   : txd_a;
      o_busy = sel ? busy_b  : busy_a;
      o_dn   = sel ? dnext_b : dnext_a;
      check_eq($sformatf("%s_txd byte=%02h k=%0d", nm, b, k), 32'(o_txd), 32'(exp_txd));
      check_eq($sformatf("%s_busy byte=%02h k=%0d", nm, b, k), 32'(o_busy), 32'd1);
      check_eq($sformatf("%s_next byte=%02h k=%0d", nm, b, k), 32'(o_dn),
               32'(more && (k == len - 1)));
      step();
    end
  endtask

  // Request handshake: DataNext low in cycle 0, high in cycle 1, line still idle.
  task automatic check_request(input bit sel);
    check_eq(sel ? "b_next_c0" : "a_next_c0", 32'(sel ? dnext_b : dnext_a), 32'd0);
    step();
    check_eq(sel ? "b_next_c1" : "a_next_c1", 32'(sel ? dnext_b : dnext_a), 32'd1);
    check_eq(sel ? "b_txd_c1" : "a_txd_c1", 32'(sel ? txd_b : txd_a), 32'd1);
    check_eq(sel ? "b_busy_c1" : "a_busy_c1", 32'(sel ? busy_b : busy_a), 32'd0);
    step();
  endtask

  initial begin
    int np0;
    logic [7:0] stream [17];
    rst = 1'b0;
    dovf_a = 1'b0; dclr_a = 1'b0; dovf_b = 1'b0; dclr_b = 1'b0;
    refresh_inputs();
    #1;
    do_reset();

    // Reset state
    check_eq("rst_txd_a", 32'(txd_a), 32'd1);
    check_eq("rst_next_a", 32'(dnext_a), 32'd0);
    check_eq("rst_busy_a", 32'(busy_a), 32'd0);
    check_eq("rst_ovf_a", 32'(ovfs_a), 32'd0);
    check_eq("rst_cnt_a", 32'(cnt_a), 32'd0);
    check_eq("rst_txd_b", 32'(txd_b), 32'd1);
    check_eq("rst_cnt_b", 32'(cnt_b), 32'd0);

    // Single byte 0xA5: 0,1,0,1,0,0,1,0,1,1 each for 4 clks
    q_a.push_back(8'hA5);
    refresh_inputs();
    check_request(1'b0);
    check_frame(1'b0, 8'hA5, 1'b0);
    check_eq("t1_busy_after", 32'(busy_a), 32'd0);
    check_eq("t1_txd_after", 32'(txd_a), 32'd1);
    check_eq("t1_cnt", 32'(cnt_a), 32'd1);

    // Back-to-back 0x00, 0xFF: two requests 40 clks apart, no idle gap
    np0 = npulse_a;
    q_a.push_back(8'h00);
    q_a.push_back(8'hFF);
    refresh_inputs();
    check_request(1'b0);
    check_frame(1'b0, 8'h00, 1'b1);
    check_frame(1'b0, 8'hFF, 1'b0);
    check_eq("t2_busy_after", 32'(busy_a), 32'd0);
    check_eq("t2_pulses", 32'(npulse_a - np0), 32'd2);
    check_eq("t2_pulse_gap", 32'(last_pulse_a - prev_pulse_a), 32'd40);
    check_eq("t2_cnt", 32'(cnt_a), 32'd3);

    // STOPBITS=2, BAUDDIV=2: 22-clk frames, next request in last stop cycle
    q_b.push_back(8'h3C);
    q_b.push_back(8'h81);
    refresh_inputs();
    check_request(1'b1);
    check_frame(1'b1, 8'h3C, 1'b1);
    check_frame(1'b1, 8'h81, 1'b0);
    check_eq("t3_busy_after", 32'(busy_b), 32'd0);
    check_eq("t3_cnt", 32'(cnt_b), 32'd2);

    // Reset during data bit 3 of 0x5A
    q_a.push_back(8'h5A);
    refresh_inputs();
    check_request(1'b0);
    for (int k = 0; k < 17; k++) step();
    check_eq("t4_txd_bit3", 32'(txd_a), 32'd1);
    rst = 1'b0;
    step();
    check_eq("t4_rst_txd", 32'(txd_a), 32'd1);
    check_eq("t4_rst_busy", 32'(busy_a), 32'd0);
    check_eq("t4_rst_next", 32'(dnext_a), 32'd0);
    check_eq("t4_rst_cnt", 32'(cnt_a), 32'd0);
    check_eq("t4_rst_cnt_b", 32'(cnt_b), 32'd0);
    rst = 1'b1;
    q_a.push_back(8'hC3);
    refresh_inputs();
    check_request(1'b0);
    check_frame(1'b0, 8'hC3, 1'b0);
    check_eq("t4_cnt_after", 32'(cnt_a), 32'd1);

    // Overflow latch: set, hold, set beats clear, clear alone
    dovf_a = 1'b1;
    step();
    dovf_a = 1'b0;
    check_eq("t5_ovf_set", 32'(ovfs_a), 32'd1);
    step();
    check_eq("t5_ovf_hold", 32'(ovfs_a), 32'd1);
    dovf_a = 1'b1; dclr_a = 1'b1;
    step();
    dovf_a = 1'b0;
    check_eq("t5_ovf_both", 32'(ovfs_a), 32'd1);
    step();
    dclr_a = 1'b0;
    check_eq("t5_ovf_clr", 32'(ovfs_a), 32'd0);
    check_eq("t5_ovf_b", 32'(ovfs_b), 32'd0);

    // Counter wrap (CNTW=4): 16th byte -> 0, 17th byte -> 1
    do_reset();
    for (int i = 0; i < 17; i++) begin
      stream[i] = 8'(i * 37 + 5);
      q_a.push_back(stream[i]);
    end
    refresh_inputs();
    check_request(1'b0);
    for (int i = 0; i < 17; i++) begin
      check_frame(1'b0, stream[i], i < 16);
      check_eq($sformatf("t6_cnt byte=%0d", i + 1), 32'(cnt_a), 32'((i + 1) % 16));
    end
    check_eq("t6_busy_after", 32'(busy_a), 32'd0);

    // DataNext never high on two consecutive cycles
    check_eq("consec_next_a", 32'(consec_a), 32'd0);
    check_eq("consec_next_b", 32'(consec_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
